// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST sequencer: FSM states and test phase tags.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR_WR,
    CLR_RD,
    DA_WR,
    DA_RD,
    DONE
  } bist_state_e;

  typedef enum logic {
    PH_CLR = 1'b0,
    PH_DA  = 1'b1
  } bist_phase_e;

endpackage

// File: rtl/mem_bist_err_log.sv
// Mismatch logger: saturating error counter plus capture of the first failing
// address, read data and phase.
module mem_bist_err_log
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cmp_en,
  input  logic [DATA_W-1:0] exp,
  input  logic [DATA_W-1:0] got,
  input  logic [ADDR_W-1:0] addr,
  input  logic              phase,
  output logic              mismatch,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              first_err_phase
);

  localparam int CNT_W = ADDR_W + 2;

  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
  bist_phase_e       first_err_phase_q, first_err_phase_d;

  assign mismatch = cmp_en && (got != exp);

  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path can infer a latch.
    err_count_d       = err_count_q;
    first_err_addr_d  = first_err_addr_q;
    first_err_data_d  = first_err_data_q;
    first_err_phase_d = first_err_phase_q;
    if (clr) begin
      err_count_d       = '0;
      first_err_addr_d  = '0;
      first_err_data_d  = '0;
      first_err_phase_d = PH_CLR;
    end else if (mismatch) begin
      if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      // The count only leaves zero on the first mismatch and never wraps.
      if (err_count_q == '0) begin
        first_err_addr_d  = addr;
        first_err_data_d  = got;
        first_err_phase_d = bist_phase_e'(phase);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (!rst_n) begin
      err_count_q       <= '0;
      first_err_addr_q  <= '0;
      first_err_data_q  <= '0;
      first_err_phase_q <= PH_CLR;
    end else begin
      err_count_q       <= err_count_d;
      first_err_addr_q  <= first_err_addr_d;
      first_err_data_q  <= first_err_data_d;
      first_err_phase_q <= first_err_phase_d;
    end
  end

  assign err_count       = err_count_q;
  assign first_err_addr  = first_err_addr_q;
  assign first_err_data  = first_err_data_q;
  assign first_err_phase = first_err_phase_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST sequencer for a synchronous RAM: CLEAR then DATA=ADDR write/read-back
// phases, with every memory-facing and status output driven from a flop.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              first_err_phase,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  localparam int                LAT_W    = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [LAT_W-1:0]  LAT_CMP  = LAT_W'(RD_LAT);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic              log_clr;
  logic              cmp_en;
  logic              mismatch;
  logic [DATA_W-1:0] exp_data;
  bist_phase_e       cmp_phase;

  // Compare strobe lands RD_LAT cycles after the read issue, on the held address.
  assign cmp_en    = ((state_q == CLR_RD) || (state_q == DA_RD)) && (lat_q == LAT_CMP);
  assign cmp_phase = (state_q == DA_RD) ? PH_DA : PH_CLR;
  assign exp_data  = (state_q == DA_RD) ? DATA_W'(addr_q) : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    pass_d  = pass_q;
    log_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR_WR;
          addr_d  = '0;
          lat_d   = '0;
          pass_d  = 1'b0;
          log_clr = 1'b1;
        end
      end
      CLR_WR, DA_WR: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_MAX) begin
          state_d = (state_q == CLR_WR) ? CLR_RD : DA_RD;
          lat_d   = '0;
        end
      end
      CLR_RD, DA_RD: begin
        if (lat_q == LAT_CMP) begin
          lat_d  = '0;
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_MAX) begin
            if (state_q == CLR_RD) begin
              state_d = DA_WR;
            end else begin
              state_d = DONE;
              // Fold in the final compare, which the counter only sees next edge.
              pass_d  = (err_count == '0) && !mismatch;
            end
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == CLR_WR) || (state_d == CLR_RD) ||
                (state_d == DA_WR)  || (state_d == DA_RD);
    done_d    = (state_d == DONE);
    write_d   = (state_d == CLR_WR) || (state_d == DA_WR);
    read_d    = ((state_d == CLR_RD) || (state_d == DA_RD)) && (lat_d == '0);
    data_in_d = (state_d == DA_WR) ? DATA_W'(addr_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lat_q     <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      read_q    <= read_d;
      write_q   <= write_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  mem_bist_err_log #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_err_log (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr             (log_clr),
    .cmp_en          (cmp_en),
    .exp             (exp_data),
    .got             (data_out),
    .addr            (addr_q),
    .phase           (cmp_phase),
    .mismatch        (mismatch),
    .err_count       (err_count),
    .first_err_addr  (first_err_addr),
    .first_err_data  (first_err_data),
    .first_err_phase (first_err_phase)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign read    = read_q;
  assign write   = write_q;
  assign addr    = addr_q;
  assign data_in = data_in_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl: default instance against a 32x8 model with
// injectable faults, plus an RD_LAT=2 instance against a two-stage read model.
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;

  logic       busy, done, pass, first_err_phase, read, write;
  logic [6:0] err_count;
  logic [4:0] first_err_addr, addr, eff_addr;
  logic [7:0] first_err_data, data_in, data_out;

  logic       busy2, done2, pass2, first_err_phase2, read2, write2;
  logic [6:0] err_count2;
  logic [4:0] first_err_addr2, addr2;
  logic [7:0] first_err_data2, data_in2, data_out2;

  int fault_mode = 0;  // 0 clean, 1 data_out[3] stuck at addr 5, 2 addr[4] ignored
  int vectors = 0;
  int miscompares = 0;
  int rw_clash = 0;
  int din_bad = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
    .first_err_phase(first_err_phase), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out)
  );

  mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_err_addr(first_err_addr2), .first_err_data(first_err_data2),
    .first_err_phase(first_err_phase2), .read(read2), .write(write2), .addr(addr2),
    .data_in(data_in2), .data_out(data_out2)
  );

  // 1-cycle memory model; data_out shows junk whenever no read is being returned.
  logic [7:0] mem1 [32];
  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  assign eff_addr = (fault_mode == 2) ? {1'b0, addr[3:0]} : addr;
  always @(posedge clk) begin
    if (write) mem1[eff_addr] <= data_in;
    v1 <= read;
    if (read) d1 <= mem1[eff_addr] | ((fault_mode == 1 && addr == 5'd5) ? 8'h08 : 8'h00);
  end
  assign data_out = v1 ? d1 : 8'hA5;

  // 2-cycle memory model for the RD_LAT=2 instance.
  logic [7:0] mem2 [32];
  logic       v2a = 1'b0, v2b = 1'b0;
  logic [7:0] d2a = 8'h00, d2b = 8'h00;
  always @(posedge clk) begin
    if (write2) mem2[addr2] <= data_in2;
    v2a <= read2;
    if (read2) d2a <= mem2[addr2];
    v2b <= v2a;
    d2b <= d2a;
  end
  assign data_out2 = v2b ? d2b : 8'h5A;

  always @(negedge clk) begin
    if ((read && write) || (read2 && write2)) rw_clash <= rw_clash + 1;
    if ((!write && data_in != 8'h00) || (!write2 && data_in2 != 8'h00)) din_bad <= din_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on the default instance and count busy cycles until done,
  // optionally pulsing start again after poke_at busy cycles.
  task automatic run1(input int poke_at, output int busy_cnt, output int done_seen);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    busy_cnt  = 0;
    done_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        done_seen = 1;
        break;
      end
      if (busy) busy_cnt++;
      start = (poke_at != 0 && busy_cnt == poke_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, ds;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy_done_pass", {busy, done, pass}, 3'b000);
    check("rst_rd_wr", {read, write}, 2'b00);
    check("rst_addr_din", {addr, data_in}, 13'h0);
    check("rst_err_log", {err_count, first_err_addr, first_err_data, first_err_phase}, 21'h0);
    rst_n = 1'b1;

    // Clean run
    run1(0, bc, ds);
    check("clean_done_seen", ds, 1);
    check("clean_busy_cycles", bc, 192);
    check("clean_pass", pass, 1'b1);
    check("clean_err_count", err_count, 7'd0);
    @(negedge clk);
    check("clean_done_pulse_and_idle", {done, busy}, 2'b00);

    // Stuck bit 3 at address 5: one error per phase
    fault_mode = 1;
    run1(0, bc, ds);
    check("stuck_busy_cycles", bc, 192);
    check("stuck_err_count", err_count, 7'd2);
    check("stuck_first_addr", first_err_addr, 5'd5);
    check("stuck_first_data", first_err_data, 8'h08);
    check("stuck_first_phase", first_err_phase, 1'b0);
    check("stuck_pass", pass, 1'b0);

    // Address bit 4 ignored: upper half overwrites lower half in DATA=ADDR
    fault_mode = 2;
    run1(0, bc, ds);
    check("alias_err_count", err_count, 7'd16);
    check("alias_first_addr", first_err_addr, 5'd0);
    check("alias_first_data", first_err_data, 8'h10);
    check("alias_first_phase", first_err_phase, 1'b1);
    check("alias_pass", pass, 1'b0);

    // Extra start pulse 50 cycles in must not restart the run
    fault_mode = 1;
    run1(50, bc, ds);
    check("restart_done_seen", ds, 1);
    check("restart_busy_cycles", bc, 192);
    check("restart_err_count", err_count, 7'd2);
    check("restart_first_addr", first_err_addr, 5'd5);
    check("restart_pass", pass, 1'b0);

    // Asynchronous reset around cycle 100, after the CLEAR-phase error
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    check("midrun_busy", busy, 1'b1);
    check("midrun_err_count", err_count, 7'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd_wr_busy", {read, write, busy}, 3'b000);
    check("async_rst_err_count", err_count, 7'd0);
    check("async_rst_first_addr", first_err_addr, 5'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fault_mode = 0;
    run1(0, bc, ds);
    check("post_rst_busy_cycles", bc, 192);
    check("post_rst_pass", pass, 1'b1);
    check("post_rst_err_count", err_count, 7'd0);

    // RD_LAT=2 instance with 2-cycle memory
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    bc = 0;
    ds = 0;
    for (int i = 0; i < 600; i++) begin
      if (done2) begin
        ds = 1;
        break;
      end
      if (busy2) bc++;
      @(negedge clk);
    end
    check("lat2_done_seen", ds, 1);
    check("lat2_busy_cycles", bc, 256);
    check("lat2_pass", pass2, 1'b1);
    check("lat2_err_count", err_count2, 7'd0);

    // Start held high through DONE: IDLE for one cycle, then a new run
    start2 = 1'b1;
    @(negedge clk);
    check("held_start_idle_cycle", busy2, 1'b0);
    @(negedge clk);
    check("held_start_rerun", busy2, 1'b1);
    start2 = 1'b0;
    ds = 0;
    for (int i = 0; i < 600; i++) begin
      if (done2) begin
        ds = 1;
        break;
      end
      @(negedge clk);
    end
    check("held_start_done_seen", ds, 1);
    check("held_start_pass", pass2, 1'b1);

    check("never_read_and_write", rw_clash, 0);
    check("data_in_zero_when_idle", din_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
